// File: rtl/psum_mem_pkg.sv
// psum_mem_pkg: shared state encoding and depth/latency constants for the psum buffer controller
package psum_mem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;
  localparam int RD_LATENCY = 2;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH_LOG2 = 12;
  localparam int DEF_FIFO_DEPTH_LOG2 = 2;
endpackage

// File: rtl/psum_mem_ctrl_if.sv
// psum_mem_ctrl_if: core memctrl0 port plus the drain stream of the psum buffer
interface psum_mem_ctrl_if
  import psum_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] memctrl0_wadd;
  logic                  memctrl0_wren;
  logic [DATA_WIDTH-1:0] memctrl0_idat;
  logic [ADDR_WIDTH-1:0] memctrl0_radd;
  logic                  memctrl0_rden;
  logic [DATA_WIDTH-1:0] memctrl0_odat;
  logic                  memctrl0_ovld;
  logic [DATA_WIDTH-1:0] o_drain_dat;
  logic                  o_drain_vld;
  logic                  i_drain_rdy;
  logic                  o_drain_last;
  modport master (
    output memctrl0_wadd, memctrl0_wren, memctrl0_idat, memctrl0_radd, memctrl0_rden, i_drain_rdy,
    input  memctrl0_odat, memctrl0_ovld, o_drain_dat, o_drain_vld, o_drain_last
  );
  modport slave (
    input  memctrl0_wadd, memctrl0_wren, memctrl0_idat, memctrl0_radd, memctrl0_rden, i_drain_rdy,
    output memctrl0_odat, memctrl0_ovld, o_drain_dat, o_drain_vld, o_drain_last
  );
endinterface

// File: rtl/psum_drain_fifo.sv
// psum_drain_fifo: small synchronous skid FIFO holding drain read data ahead of the stream port
module psum_drain_fifo
  import psum_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_WIDTH-1:0]    i_dat,
  input  logic                     i_pop,
  output logic [DATA_WIDTH-1:0]    o_dat,
  output logic [FIFO_DEPTH_LOG2:0] o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int FL = FIFO_DEPTH_LOG2;
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<FL)-1];
  logic [FL-1:0] r_wp, r_rp;
  logic [FL:0]   r_cnt;
  logic          w_push, w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full  = r_cnt == (FL+1)'(1 << FL);
  assign o_empty = r_cnt == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp  <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + {{FL{1'b0}}, w_push} - {{FL{1'b0}}, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_dat;
endmodule

// File: rtl/psum_mem_ctrl.sv
// psum_mem_ctrl: owns the psum BRAM; serves core RMW traffic, host zero-fill and a
// credit-limited drain stream with ready/valid backpressure
module psum_mem_ctrl
  import psum_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH_LOG2 = DEF_MEM_DEPTH_LOG2,
  parameter int FIFO_DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  psum_mem_ctrl_if.slave          bus,
  input  logic                    i_clear_start,
  input  logic                    i_drain_start,
  input  logic [MEM_DEPTH_LOG2-1:0] i_drain_base,
  input  logic [MEM_DEPTH_LOG2:0] i_drain_len,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);
  localparam int ML = MEM_DEPTH_LOG2;
  localparam int FD = 1 << FIFO_DEPTH_LOG2;
  localparam logic [ML:0] LAST_ADDR = (ML+1)'((1 << ML) - 1);
  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ML)-1];
  logic [DATA_WIDTH-1:0] r_rd1, r_odat, w_wdat, w_fdat;
  logic [ML:0] r_cnt, r_beat, r_len;
  logic [ML-1:0] r_base, w_waddr, w_raddr;
  logic [FIFO_DEPTH_LOG2:0] w_fcount;
  logic r_cv1, r_cz1, r_ovld, r_dv1, r_done, r_err;
  logic w_idle, w_wr_oor, w_rd_oor, w_core_we, w_core_re, w_clr_we, w_we, w_byp;
  logic w_issue, w_pop, w_last_beat, w_done, w_err_set, w_start, w_full, w_empty;
  assign w_idle    = r_state == IDLE;
  assign w_wr_oor  = |(bus.memctrl0_wadd >> ML);
  assign w_rd_oor  = |(bus.memctrl0_radd >> ML);
  assign w_core_we = bus.memctrl0_wren && w_idle && !w_wr_oor;
  assign w_core_re = bus.memctrl0_rden && w_idle && !w_rd_oor;
  assign w_clr_we  = r_state == CLEAR;
  assign w_we      = w_core_we || w_clr_we;
  assign w_waddr   = w_clr_we ? r_cnt[ML-1:0] : bus.memctrl0_wadd[ML-1:0];
  assign w_wdat    = w_clr_we ? '0 : bus.memctrl0_idat;
  // in-flight reads count against FIFO space so the skid buffer can never overflow
  assign w_issue   = r_state == DRAIN && r_cnt != r_len && !w_full &&
                     (int'(w_fcount) + int'(r_dv1)) < FD;
  assign w_raddr   = w_issue ? r_base + r_cnt[ML-1:0] : bus.memctrl0_radd[ML-1:0];
  assign w_byp     = w_core_we && w_core_re && bus.memctrl0_wadd == bus.memctrl0_radd;
  assign w_pop     = !w_empty && bus.i_drain_rdy;
  assign w_last_beat = r_beat == r_len - 1'b1;
  assign w_start   = w_idle && (i_clear_start || i_drain_start);
  assign w_err_set = (bus.memctrl0_wren && w_wr_oor) || (bus.memctrl0_rden && w_rd_oor) ||
                     (!w_idle && (bus.memctrl0_wren || bus.memctrl0_rden || i_clear_start || i_drain_start)) ||
                     (w_idle && i_clear_start && i_drain_start);
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = i_clear_start ? CLEAR : (i_drain_start && i_drain_len != '0) ? DRAIN : IDLE;
        w_done = !i_clear_start && i_drain_start && i_drain_len == '0;
      end
      CLEAR: begin
        w_next = r_cnt == LAST_ADDR ? IDLE : CLEAR;
        w_done = r_cnt == LAST_ADDR;
      end
      DRAIN: begin
        w_next = (w_pop && w_last_beat) ? IDLE : DRAIN;
        w_done = w_pop && w_last_beat;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_dv1   <= 1'b0;
      r_cv1   <= 1'b0;
      r_cz1   <= 1'b0;
      r_ovld  <= 1'b0;
      r_odat  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      r_err   <= r_err || w_err_set;
      r_cnt   <= w_start ? '0 : (w_clr_we || w_issue) ? r_cnt + 1'b1 : r_cnt;
      r_beat  <= w_start ? '0 : r_beat + {{ML{1'b0}}, w_pop};
      r_len   <= w_start ? i_drain_len : r_len;
      r_base  <= w_start ? i_drain_base : r_base;
      r_dv1   <= w_issue;
      r_cv1   <= bus.memctrl0_rden;
      r_cz1   <= !w_core_re;
      r_ovld  <= r_cv1;
      r_odat  <= r_cz1 ? '0 : r_rd1;
    end
  // write-first: a same-cycle hit returns the incoming word instead of the old contents
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdat;
    r_rd1 <= w_byp ? bus.memctrl0_idat : r_mem[w_raddr];
  end
  psum_drain_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(r_dv1),
    .i_dat(r_rd1),
    .i_pop(w_pop),
    .o_dat(w_fdat),
    .o_count(w_fcount),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign bus.memctrl0_odat = r_odat;
  assign bus.memctrl0_ovld = r_ovld;
  assign bus.o_drain_dat   = w_fdat;
  assign bus.o_drain_vld   = !w_empty;
  assign bus.o_drain_last  = !w_empty && w_last_beat;
  assign o_busy = r_state != IDLE || r_done;
  assign o_done = r_done;
  assign o_err  = r_err;
endmodule

// File: tb/tb_psum_mem_ctrl.sv
// tb_psum_mem_ctrl: scoreboard bench; an array model of the buffer predicts core reads and
// drain beats, a negedge monitor pops and compares whatever the DUT presents
module tb_psum_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  psum_mem_ctrl_if bus ();
  logic clear_start, drain_start, busy, done, err;
  logic [11:0] drain_base;
  logic [12:0] drain_len;
  psum_mem_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .i_clear_start(clear_start), .i_drain_start(drain_start),
    .i_drain_base(drain_base), .i_drain_len(drain_len),
    .o_busy(busy), .o_done(done), .o_err(err)
  );
  typedef struct {logic [31:0] dat; int cyc; bit chk;} rd_t;
  typedef struct {logic [31:0] dat; bit last;} dr_t;
  rd_t core_q[$];
  dr_t drain_q[$];
  logic [31:0] mdl [4096];
  bit known [4096];
  bit busy_m = 0;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, beats = 0, vld_cycles = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0, done_cyc = 0;
  int rdy_mode = 0, rdy_idx = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // ready pattern: 0=always, 1=1,0,0 repeating, 2=random, 3=held low
  initial forever begin
    @(posedge clk);
    #1;
    bus.i_drain_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (rdy_idx % 3 == 0) :
                      rdy_mode == 2 ? 1'($urandom % 2) : 1'b0;
    rdy_idx++;
  end
  always @(negedge clk) begin
    rd_t ce;
    dr_t de;
    if (rst) begin
      if (bus.memctrl0_ovld) begin
        if (core_q.size() == 0) check("core_unexpected_ovld", 1, 0);
        else begin
          ce = core_q.pop_front();
          if (ce.chk) check("core_odat", bus.memctrl0_odat, ce.dat);
          check("core_latency", cyc, ce.cyc + 2);
        end
      end
      if (bus.o_drain_vld) vld_cycles++;
      if (bus.o_drain_vld && bus.i_drain_rdy) begin
        if (drain_q.size() == 0) check("drain_unexpected_beat", 1, 0);
        else begin
          de = drain_q.pop_front();
          check("drain_dat", bus.o_drain_dat, de.dat);
          check("drain_last", bus.o_drain_last, de.last);
        end
        if (beats == 0) first_cyc = cyc;
        beats++;
        last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic core_op(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                         input bit re, input logic [31:0] ra);
    rd_t e;
    bus.memctrl0_wren = we;
    bus.memctrl0_wadd = wa;
    bus.memctrl0_idat = wd;
    bus.memctrl0_rden = re;
    bus.memctrl0_radd = ra;
    if (re) begin
      e.cyc = cyc;
      e.chk = 1;
      if (ra >= 4096 || busy_m) e.dat = 0;
      else if (we && wa == ra) e.dat = wd;
      else begin
        e.dat = mdl[ra[11:0]];
        e.chk = known[ra[11:0]];
      end
      core_q.push_back(e);
    end
    if (we && wa < 4096 && !busy_m) begin
      mdl[wa[11:0]] = wd;
      known[wa[11:0]] = 1;
    end
    @(negedge clk);
    bus.memctrl0_wren = 0;
    bus.memctrl0_rden = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    busy_m = 0;
    core_q.delete();
    drain_q.delete();
    for (int i = 0; i < 4096; i++) known[i] = 0;
    idle(3);
    rst = 1;
    idle(1);
  endtask
  task automatic push_drain(input int base, input int len);
    dr_t e;
    for (int i = 0; i < len; i++) begin
      e.dat = mdl[(base + i) % 4096];
      e.last = i == len - 1;
      drain_q.push_back(e);
    end
  endtask
  task automatic clear(input bit inj);
    int t, bc;
    rd_t e;
    clear_start = 1;
    @(negedge clk);
    clear_start = 0;
    busy_m = 1;
    t = 0;
    bc = 0;
    while (!done && t < 5000) begin
      if (busy) bc++;
      if (inj && t == 100) begin
        bus.memctrl0_wren = 1; bus.memctrl0_wadd = 10; bus.memctrl0_idat = 32'hBEEF;
        bus.memctrl0_rden = 1; bus.memctrl0_radd = 4000;
        e.dat = 0; e.cyc = cyc; e.chk = 1;
        core_q.push_back(e);
      end
      @(negedge clk);
      bus.memctrl0_wren = 0;
      bus.memctrl0_rden = 0;
      t++;
    end
    busy_m = 0;
    for (int i = 0; i < 4096; i++) begin
      mdl[i] = 0;
      known[i] = 1;
    end
    check("clear_busy_cycles", bc, 4096);
    check("clear_done", done, 1);
    check("clear_busy_at_done", busy, 1);
    @(negedge clk);
    check("clear_done_single", done, 0);
    check("clear_idle_after", busy, 0);
  endtask
  task automatic drain(input int base, input int len, input int mode, input bit inj);
    int k, t, d0;
    push_drain(base, len);
    rdy_mode = mode;
    rdy_idx = 0;
    beats = 0;
    vld_cycles = 0;
    d0 = done_cnt;
    drain_base = 12'(base);
    drain_len = 13'(len);
    drain_start = 1;
    k = cyc;
    busy_m = len != 0;
    @(negedge clk);
    drain_start = 0;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      if (inj && t == 5) clear_start = 1;
      if (inj && t == 6) begin
        clear_start = 0;
        check("drain_busy_after_clear_req", busy, 1);
        rdy_mode = 2;
      end
      @(negedge clk);
      t++;
    end
    busy_m = 0;
    check("drain_done_count", done_cnt - d0, 1);
    check("drain_beats", beats, len);
    if (len == 0) begin
      check("zero_len_done_cyc", done_cyc, k + 1);
      check("zero_len_vld", vld_cycles, 0);
    end else check("drain_done_after_last", done_cyc, last_cyc + 1);
    if (mode == 0 && len > 0) begin
      check("drain_first_beat_cyc", first_cyc, k + 3);
      check("drain_throughput", done_cyc, k + 3 + len);
    end
    check("drain_q_empty", drain_q.size(), 0);
    rdy_mode = 0;
  endtask
  initial begin
    int t;
    bus.memctrl0_wren = 0; bus.memctrl0_rden = 0;
    bus.memctrl0_wadd = 0; bus.memctrl0_radd = 0; bus.memctrl0_idat = 0;
    clear_start = 0; drain_start = 0; drain_base = 0; drain_len = 0;
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovld", bus.memctrl0_ovld, 0);
    check("rst_vld", bus.o_drain_vld, 0);
    rst = 1;
    idle(1);
    core_op(1, 5, 32'h1234, 0, 0);
    core_op(0, 0, 0, 1, 5);
    core_op(1, 6, 32'h6666, 0, 0);
    core_op(1, 7, 32'h7777, 0, 0);
    core_op(0, 0, 0, 1, 5);
    core_op(0, 0, 0, 1, 6);
    core_op(0, 0, 0, 1, 7);
    idle(4);
    core_op(1, 9, 32'hAA, 1, 9);
    idle(3);
    core_op(0, 0, 0, 1, 9);
    idle(2);
    core_op(1, 9, mdl[9] + 1, 0, 0);
    core_op(0, 0, 0, 1, 9);
    idle(3);
    core_op(1, 0, 32'hDEAD, 0, 0);
    core_op(1, 100, 32'h100, 0, 0);
    core_op(1, 4095, 32'hFFF, 0, 0);
    clear(0);
    check("no_err_after_clean_ops", err, 0);
    core_op(0, 0, 0, 1, 0);
    core_op(0, 0, 0, 1, 100);
    core_op(0, 0, 0, 1, 4095);
    idle(3);
    for (int k = 0; k < 4096; k++) core_op(1, k, k, 0, 0);
    drain(4094, 4, 1, 0);
    drain(10, 20, 0, 0);
    drain(100, 4096, 0, 0);
    for (int r = 0; r < 8; r++) begin
      repeat (6) core_op(1'($urandom % 2), $urandom % 4096, $urandom, 1'($urandom % 2), $urandom % 4096);
      idle(3);
      drain($urandom % 4096, 1 + $urandom % 40, 2, 0);
    end
    drain(0, 0, 0, 0);
    check("no_err_after_drains", err, 0);
    do_reset();
    check("err_clear_a", err, 0);
    core_op(1, 0, 32'h77, 0, 0);
    core_op(1, 32'h1000, 32'h99, 0, 0);
    check("err_oor_write", err, 1);
    core_op(0, 0, 0, 1, 0);
    core_op(0, 0, 0, 1, 32'h1000);
    idle(3);
    do_reset();
    check("err_clear_b", err, 0);
    core_op(1, 10, 32'h5, 0, 0);
    clear(1);
    check("err_write_in_clear", err, 1);
    core_op(0, 0, 0, 1, 10);
    idle(3);
    do_reset();
    check("err_clear_c", err, 0);
    for (int k = 0; k < 8; k++) core_op(1, k, $urandom, 0, 0);
    drain(0, 8, 3, 1);
    check("err_start_in_drain", err, 1);
    check("err_pre_async", err, 1);
    push_drain(0, 8);
    rdy_mode = 0;
    beats = 0;
    drain_base = 0;
    drain_len = 8;
    drain_start = 1;
    @(negedge clk);
    drain_start = 0;
    t = 0;
    while (beats < 1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_vld", bus.o_drain_vld, 1);
    check("pre_rst_busy", busy, 1);
    #2 rst = 0;
    #1;
    check("async_rst_vld", bus.o_drain_vld, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_err", err, 0);
    core_q.delete();
    drain_q.delete();
    for (int i = 0; i < 4096; i++) known[i] = 0;
    idle(2);
    rst = 1;
    idle(1);
    check("post_rst_idle", busy, 0);
    check("post_rst_vld", bus.o_drain_vld, 0);
    for (int k = 0; k < 6; k++) core_op(1, k, $urandom, 0, 0);
    drain(0, 6, 2, 0);
    idle(4);
    check("core_q_empty", core_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
